// File: rtl/des_key_schedule_ctrl.sv
// DES key schedule controller: walks the subkey generator through
// key IDs 1..16, caches the subkeys and serves them by round.
module des_key_schedule_ctrl #(
  parameter int NUM_ROUNDS  = 16,
  parameter int GEN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [1:64] key_in,
  output logic        busy,
  output logic        keys_valid,
  output logic        err,
  output logic        gen_start,
  output logic [5:0]  gen_keyid,
  output logic [1:64] gen_key,
  input  logic        gen_ready,
  input  logic [1:48] gen_subkey,
  input  logic [3:0]  rd_round,
  input  logic        rd_decrypt,
  output logic [1:48] rd_subkey
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RELEASE
  } state_t;

  localparam int TW = $clog2(GEN_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(GEN_TIMEOUT - 1);
  localparam logic [4:0] KLAST = 5'(NUM_ROUNDS);

  state_t state, state_nx;
  logic [4:0] k, k_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic busy_nx, kv_nx, err_nx, start_nx;
  logic [5:0] keyid_nx;
  logic [1:64] key_nx;
  logic wr_en;
  logic [3:0] wr_idx;
  logic [3:0] rd_idx;
  logic [1:48] slot [NUM_ROUNDS];

  assign wr_idx = 4'(k - 5'd1);
  assign rd_idx = rd_decrypt ? 4'd15 - rd_round : rd_round;

  // Control state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= 5'd1;
      tcnt       <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      err        <= 1'b0;
      gen_start  <= 1'b0;
      gen_keyid  <= 6'd1;
      gen_key    <= '0;
    end else begin
      state      <= state_nx;
      k          <= k_nx;
      tcnt       <= tcnt_nx;
      busy       <= busy_nx;
      keys_valid <= kv_nx;
      err        <= err_nx;
      gen_start  <= start_nx;
      gen_keyid  <= keyid_nx;
      gen_key    <= key_nx;
    end
  end

  // Next-state: one start/ready handshake per subkey, with watchdog.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    tcnt_nx  = tcnt;
    busy_nx  = busy;
    kv_nx    = keys_valid;
    err_nx   = err;
    start_nx = gen_start;
    keyid_nx = gen_keyid;
    key_nx   = gen_key;
    wr_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          key_nx   = key_in;
          k_nx     = 5'd1;
          kv_nx    = 1'b0;
          err_nx   = 1'b0;
          busy_nx  = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        keyid_nx = {1'b0, k};
        start_nx = 1'b1;
        tcnt_nx  = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (gen_ready) begin
          wr_en    = 1'b1;
          start_nx = 1'b0;
          tcnt_nx  = '0;
          state_nx = RELEASE;
        end else if (tcnt == TLAST) begin
          err_nx   = 1'b1;
          start_nx = 1'b0;
          busy_nx  = 1'b0;
          kv_nx    = 1'b0;
          state_nx = IDLE;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      RELEASE: begin
        if (!gen_ready) begin
          if (k == KLAST) begin
            kv_nx    = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end else begin
            k_nx     = k + 5'd1;
            state_nx = REQ;
          end
        end else if (tcnt == TLAST) begin
          err_nx   = 1'b1;
          start_nx = 1'b0;
          busy_nx  = 1'b0;
          kv_nx    = 1'b0;
          state_nx = IDLE;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subkey cache, written once per completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROUNDS; i++) slot[i] <= '0;
    end else if (wr_en) begin
      slot[wr_idx] <= gen_subkey;
    end
  end

  // Registered read port; zero until the cache is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_subkey <= '0;
    else rd_subkey <= keys_valid ? slot[rd_idx] : '0;
  end

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// Bench for des_key_schedule_ctrl: DES generator model, event-level
// reference model and per-cycle compare.
module tb_des_key_schedule_ctrl;
  localparam int GT = 64;
  localparam logic [63:0] K0 = 64'h133457799BBCDFF1;
  localparam logic [47:0] SK1 = 48'h1B02EFFC7072;
  localparam logic [47:0] SK2 = 48'h79AED9DBC9E5;
  localparam logic [47:0] SK16 = 48'hCB3D8B0E17F5;

  localparam int PC1[56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2[48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH[16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic load;
  logic [1:64] key_in;
  logic busy, keys_valid, err, gen_start;
  logic [5:0] gen_keyid;
  logic [1:64] gen_key;
  logic gen_ready;
  logic [1:48] gen_subkey;
  logic [3:0] rd_round;
  logic rd_decrypt;
  logic [1:48] rd_subkey;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_at = -1;
  int to_at = -1;
  bit gen_stall = 1'b0;
  int n_edges = 0;

  always #5 clk = ~clk;

  des_key_schedule_ctrl #(.NUM_ROUNDS(16), .GEN_TIMEOUT(GT)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .key_in(key_in),
    .busy(busy), .keys_valid(keys_valid), .err(err),
    .gen_start(gen_start), .gen_keyid(gen_keyid), .gen_key(gen_key),
    .gen_ready(gen_ready), .gen_subkey(gen_subkey),
    .rd_round(rd_round), .rd_decrypt(rd_decrypt),
    .rd_subkey(rd_subkey));

  function automatic logic [47:0] des_subkey(input logic [63:0] key,
                                             input int id);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] r;
    for (int j = 0; j < 56; j++) cd[55-j] = key[64-PC1[j]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < id; i++)
      for (int s = 0; s < SH[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    cd = {c, d};
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Generator model: random latency, releases ready after start falls.
  initial begin
    int gph, lat, sid;
    gph = 0; lat = 0; sid = 0;
    gen_ready = 1'b0;
    gen_subkey = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        gen_ready = 1'b0;
        gph = 0;
        done_at = -1;
        to_at = -1;
      end else begin
        case (gph)
          0: if (gen_start) begin
               if (gen_stall) begin
                 to_at = cyc + GT + 1;
                 gph = 4;
               end else begin
                 lat = int'($urandom_range(0, 3));
                 sid = int'(gen_keyid);
                 gph = 1;
               end
             end
          1: if (lat == 0) begin
               gen_ready = 1'b1;
               gen_subkey = des_subkey(gen_key, sid);
               gph = 2;
             end else lat--;
          2: if (!gen_start) begin
               lat = int'($urandom_range(0, 2));
               gph = 3;
             end
          3: if (lat == 0) begin
               gen_ready = 1'b0;
               gph = 0;
               if (sid == 16) done_at = cyc + 2;
             end else lat--;
          4: if (!gen_start) gph = 0;
          default: gph = 0;
        endcase
      end
    end
  end

  // Reference model and per-cycle compare.
  initial begin
    bit m_busy, m_kv, m_err, p_load, p_kv, p_start, p_dec;
    logic [63:0] m_key, p_key, exp_rd;
    logic [3:0] p_rd;
    int m_id, idx;
    m_busy = 0; m_kv = 0; m_err = 0; m_key = '0; m_id = 1;
    p_load = 0; p_kv = 0; p_start = 0; p_dec = 0; p_key = '0; p_rd = '0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_kv = 0; m_err = 0; m_key = '0; m_id = 1;
        chk("rst_busy", busy, 0);
        chk("rst_keys_valid", keys_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_gen_start", gen_start, 0);
        chk("rst_gen_keyid", gen_keyid, 1);
        chk("rst_gen_key", gen_key, 0);
        chk("rst_rd_subkey", rd_subkey, 0);
        p_load = 0;
        p_kv = 0;
        p_start = 0;
      end else begin
        idx = p_dec ? 15 - int'(p_rd) : int'(p_rd);
        exp_rd = p_kv ? 64'(des_subkey(m_key, idx + 1)) : 64'h0;
        chk("rd_subkey", rd_subkey, exp_rd);
        if (p_load && !m_busy) begin
          m_busy = 1; m_kv = 0; m_err = 0; m_key = p_key; m_id = 1;
          n_edges = 0;
        end
        if (cyc == done_at) begin
          m_kv = 1;
          m_busy = 0;
        end
        if (cyc == to_at) begin
          m_err = 1;
          m_busy = 0;
          m_kv = 0;
        end
        if (gen_start && !p_start) begin
          chk("gen_keyid_order", gen_keyid, 64'(m_id));
          m_id++;
          n_edges++;
        end
        chk("busy", busy, 64'(m_busy));
        chk("keys_valid", keys_valid, 64'(m_kv));
        chk("err", err, 64'(m_err));
        chk("gen_key", gen_key, m_key);
        if (!m_busy) chk("gen_start_idle", gen_start, 0);
        p_load = load;
        p_kv = m_kv;
        p_start = gen_start;
      end
      p_key = key_in;
      p_rd = rd_round;
      p_dec = rd_decrypt;
    end
  end

  task automatic do_load(input logic [63:0] k);
    load = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input bit noise);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      rd_round = 4'($urandom_range(0, 15));
      rd_decrypt = 1'($urandom_range(0, 1));
      if (noise) begin
        load = ($urandom_range(0, 5) == 0);
        key_in = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      n++;
    end
    load = 1'b0;
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic wait_req(input int id);
    int n;
    n = 0;
    while (!(gen_start && int'(gen_keyid) == id) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_req: keyid %0d never requested", id);
    end
  endtask

  task automatic rd(input logic [3:0] r, input logic d,
                    input logic [47:0] exp, input string nm);
    rd_round = r;
    rd_decrypt = d;
    @(posedge clk); #1;
    chk(nm, rd_subkey, exp);
  endtask

  initial begin
    logic [63:0] rk;
    int n;
    rst_n = 1'b0;
    load = 1'b0;
    key_in = '0;
    rd_round = '0;
    rd_decrypt = 1'b0;
    chk("model_sk1", des_subkey(K0, 1), SK1);
    chk("model_sk2", des_subkey(K0, 2), SK2);
    chk("model_sk16", des_subkey(K0, 16), SK16);
    rd_round = 4'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_subkey", rd_subkey, 0);
    chk("reset_keyid", gen_keyid, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd(4'd5, 1'b0, 48'h0, "rd_before_load");

    do_load(K0);
    chk("busy_after_load", busy, 1);
    wait_done(1'b1);
    chk("sched_edges", n_edges, 16);
    chk("sched_kv", keys_valid, 1);
    chk("sched_busy", busy, 0);
    rd(4'd0, 1'b0, SK1, "enc_r0");
    rd(4'd15, 1'b0, SK16, "enc_r15");
    rd(4'd0, 1'b1, SK16, "dec_r0");
    rd(4'd15, 1'b1, SK1, "dec_r15");

    do_load(K0);
    wait_req(5);
    do_load(64'h0);
    wait_done(1'b0);
    chk("busy_load_key", gen_key, K0);
    chk("busy_load_kv", keys_valid, 1);
    rd(4'd0, 1'b0, SK1, "busy_load_r0");
    rd(4'd15, 1'b0, SK16, "busy_load_r15");

    gen_stall = 1'b1;
    do_load(K0);
    n = 0;
    while (!gen_start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    while (!err && n < GT + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_cycles", n, GT);
    chk("timeout_err", err, 1);
    chk("timeout_start", gen_start, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_kv", keys_valid, 0);
    gen_stall = 1'b0;
    do_load(K0);
    chk("err_cleared", err, 0);
    wait_done(1'b1);
    chk("after_to_kv", keys_valid, 1);
    rd(4'd1, 1'b0, SK2, "after_to_r1");

    do_load(K0);
    wait_req(7);
    #2 rst_n = 1'b0;
    #1 chk("async_start_drop", gen_start, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_kv", keys_valid, 0);
    for (int r = 0; r < 16; r += 5)
      rd(4'(r), 1'b0, 48'h0, "post_rst_rd");
    do_load(K0);
    wait_done(1'b1);
    rd(4'd0, 1'b0, SK1, "post_rst_r0");

    for (int t = 0; t < 3; t++) begin
      rk = {$urandom, $urandom};
      do_load(rk);
      wait_done(1'b1);
      for (int r = 0; r < 16; r++) begin
        logic d;
        d = 1'($urandom_range(0, 1));
        rd(4'(r), d, des_subkey(rk, d ? 16 - r : r + 1), "rand_rd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule_ctrl.md
Name: des_key_schedule_ctrl

Overview:
Sequences the 48-bit subkey generator through key IDs 1..16 for a new 64-bit DES key and caches all 16 subkeys in an internal register file. It drives the generator's start/ready handshake, one request per round, with a timeout watchdog. It serves round subkeys to the round datapath in encrypt order or reversed decrypt order through a registered read port.

Parameters:
NUM_ROUNDS, 16, number of subkeys scheduled and cached; fixed at 16 for DES.
GEN_TIMEOUT, 64, maximum cycles allowed in WAIT or RELEASE before the schedule aborts with err.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
load  input  1  single-cycle request to capture key_in and start a schedule; sampled only in IDLE.
key_in  input  [1:64]  64-bit DES key, bit 1 = MSB.
busy  output  1  high while a schedule is in progress.
keys_valid  output  1  high once all 16 slots hold subkeys for the current key.
err  output  1  sticky generator-timeout flag; cleared by the next accepted load.
gen_start  output  1  start level to the subkey generator.
gen_keyid  output  6  subkey ID to the generator, 1..16.
gen_key  output  [1:64]  latched key to the generator.
gen_ready  input  1  generator completion flag; the generator clears it after gen_start falls.
gen_subkey  input  [1:48]  generator result, valid while gen_ready=1.
rd_round  input  4  round index requested by the datapath, 0..15.
rd_decrypt  input  1  1 = reversed order for decryption.
rd_subkey  output  [1:48]  registered subkey for rd_round.

Behaviour:
- Reset values: busy=0, keys_valid=0, err=0, gen_start=0, gen_keyid=1, gen_key=0, rd_subkey=0, all 16 slots=0, state=IDLE, round counter k=1, timeout counter=0.
- States: IDLE, REQ, WAIT, RELEASE.
- IDLE, load=1: on the next edge, latch gen_key=key_in; set k=1, keys_valid=0, err=0, busy=1; go to REQ.
- IDLE, load=0: hold all outputs.
- REQ: drive gen_keyid=k and gen_start=1; go to WAIT; clear the timeout counter.
- WAIT: hold gen_start=1.
  - On gen_ready=1: write gen_subkey into slot k-1, drive gen_start=0, go to RELEASE, clear the timeout counter.
- RELEASE: keep gen_start=0 until gen_ready=0. This guarantees gen_start is low for at least one cycle, so the generator sees a fresh rising edge on the next request.
  - When gen_ready=0 and k<16: increment k and go to REQ.
  - When gen_ready=0 and k=16: go to IDLE with keys_valid=1 and busy=0.
- Timeout: in WAIT or RELEASE, the counter increments each cycle. When it reaches GEN_TIMEOUT, set err=1, gen_start=0, busy=0, keys_valid=0 and go to IDLE.
- load during REQ, WAIT or RELEASE is ignored; the key and schedule are not disturbed.
- load together with the final RELEASE exit is also ignored, because it was not sampled in IDLE.
- Round latency: one request per subkey, minimum 4 cycles of overhead per round beyond the generator's own latency.
- Read port, one-cycle latency:
  - Slot index = rd_decrypt ? 15-rd_round : rd_round.
  - rd_subkey <= keys_valid ? slot[index] : 0.
  - Reads are allowed during a schedule but return 0 until keys_valid=1.
- Slot writes and reads in the same cycle to the same slot: the read returns the old value.
- Reset mid-schedule: everything returns to reset values immediately and gen_start drops asynchronously.

Test Plan:
1. Reset: assert rst_n=0 for 3 cycles -> every output at its reset value; rd_subkey=0 for any rd_round.
2. Full schedule: load key_in=64'h133457799BBCDFF1 with the real generator attached -> exactly 16 gen_start rising edges with gen_keyid 1..16 in order, then keys_valid=1 and busy=0. Then rd_round=0, rd_decrypt=0 -> rd_subkey=48'h1B02EFFC7072 one cycle later; rd_round=15 -> 48'hCB3D8B0E17F5.
3. Decrypt order, after scenario 2: rd_round=0, rd_decrypt=1 -> 48'hCB3D8B0E17F5; rd_round=15, rd_decrypt=1 -> 48'h1B02EFFC7072.
4. Load while busy: pulse load with key_in=64'h0 at the 5th request -> schedule completes, gen_key stays 133457799BBCDFF1, and subkeys match scenario 2.
5. Timeout: generator model holds gen_ready=0 -> err=1 exactly GEN_TIMEOUT cycles after WAIT entry, with gen_start=0, busy=0, keys_valid=0. A following valid load clears err and completes the schedule.
6. Reset mid-schedule: assert rst_n low in WAIT for round 7 -> gen_start=0 immediately. After release, keys_valid=0 and all reads return 0 until a new load completes.
